sd_req_sched: RTL
=================

// Module: sd_req_sched
// PURPOSE
//  Schedules block read/write requests from N virtual-drive clients (HDD, floppy 1, floppy 2) onto the hps_io sd_rd/sd_wr/sd_ack handshake.
//  Latches request pulses, grants one transfer at a time round-robin, runs the ack handshake and drives per-client busy (cpu_wait) and done.
//  Sits in emu between the drive controllers (iigs HDD port, floppy_track) and hps_io, so only one SD transfer is ever outstanding.
// PARAMETERS
//  NCH      3       number of clients; index 0 = HDD; valid range 1..4
//  TIMEOUT  2**24   clk_sys cycles allowed from grant to ack fall (SD_SCHED_TIMEOUT_EN only)
// PORTS
//  clk_sys      in   1        system clock
//  reset_n      in   1        async active-low reset
//  req_rd       in   NCH      per-client read request pulse (level is also accepted)
//  req_wr       in   NCH      per-client write request pulse
//  mounted      in   NCH      img_mounted pulse; cancels that client's pending request
//  sd_rd        out  NCH      to hps_io sd_rd
//  sd_wr        out  NCH      to hps_io sd_wr
//  sd_ack       in   NCH      from hps_io sd_ack
//  busy         out  NCH      client has pending or active transfer (drives cpu_wait)
//  done         out  NCH      1-cycle pulse when the client's transfer completes
//  grant        out  2        index of active client; valid while active=1
//  active       out  1        a transfer is in progress
//  err          out  NCH      sticky timeout flag, cleared on the client's next request
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, all outputs 0, pending 0, RR pointer 0.
//  Pending latch per client: pend_rd |= req_rd, pend_wr |= req_wr; a mounted pulse clears both (same-cycle req loses).
//  busy[i] = pend_rd[i] | pend_wr[i] | (active & grant==i); registered, rises 1 cycle after the req.
//  FSM:
//   IDLE: search clients from rr_ptr upward (wrap at NCH-1) for the first with pending; on hit grant=i,
//         active=1, go REQ next cycle. A request arriving during IDLE is granted no earlier than 2 cycles after it.
//   REQ: assert sd_wr[i] if pend_wr[i], else sd_rd[i] (write has priority; never both). On sd_ack[i] rising
//        edge (registered old_ack): drop sd_rd/sd_wr, clear only the served pending bit, go XFER.
//   XFER: wait for sd_ack[i] falling edge -> DONE.
//   DONE: done[i]=1 for one cycle, active=0, rr_ptr=(i+1) mod NCH, go IDLE.
//  Edge detect uses one old_ack register per client; acks on non-granted clients are ignored.
//  Requests from the granted client during REQ/XFER re-set its pending bit and are served later (not merged).
//  mounted[i] while i is granted: pending cleared, transfer still runs to ack fall (hps_io must finish); done still pulses.
//  Both pend_rd and pend_wr set: write served first, read stays pending for a later grant.
//  Reset mid-transfer: sd_rd/sd_wr drop at once; hps_io ack is ignored until the return to IDLE.
//  Worst-case wait for any client: NCH-1 complete transfers (starvation-free).
// CONFIGURATION
//  SD_SCHED_TIMEOUT_EN defined: a 25-bit counter runs in REQ/XFER. At TIMEOUT: drop sd_rd/sd_wr,
//   set err[i], clear the served pending bit, pulse done[i], go IDLE with rr_ptr advanced.
//  Not defined: no counter; err tied 0; the FSM waits on ack indefinitely.
// TESTING
//  1. NCH=3, req_rd[0] pulse; ack[0] high 3 cycles after sd_rd[0], low 600 cycles later -> sd_rd[0] for 3 cycles;
//     busy[0] 1 until done[0]; done[0] 1 cycle after ack fall.
//  2. req_rd[1] and req_wr[2] in the same cycle, rr_ptr=0 -> client 1 (read) served first, then client 2 (sd_wr[2]);
//     rr_ptr ends at 0.
//  3. req_rd[0] and req_wr[0] together -> sd_wr[0] transfer first, then sd_rd[0]; two done[0] pulses.
//  4. mounted[2] during REQ of client 2 with ack arriving -> transfer completes and done[2] pulses;
//     a second queued req on 2 cancelled, busy[2]=0 afterwards.
//  5. reset_n low during XFER -> sd_*, busy, active 0 at once; after release, stale ack fall gives no done pulse.
//  6. SD_SCHED_TIMEOUT_EN, TIMEOUT=100, no ack -> at cycle 100 sd_rd drops, err=1, done pulses; next req clears err.

Source files
------------

// File: rtl/sd_req_sched.sv
// -----------------------------------------------------------------------------
// sd_req_sched
// Round-robin scheduler that funnels block read/write requests from NCH
// virtual-drive clients (0 = HDD, 1/2 = floppies) onto the single hps_io
// sd_rd/sd_wr/sd_ack handshake, so only one SD transfer is outstanding at a time.
//
// Optional feature macro: SD_SCHED_TIMEOUT_EN
//   defined   : a 25-bit watchdog runs while a transfer is in REQ/XFER. After
//               TIMEOUT cycles it aborts the transfer, sets err[i] and pulses done[i].
//   undefined : no watchdog, err is tied to 0 and the FSM waits on ack forever.
//
// Ports
//   clk_sys  in   1    system clock
//   reset_n  in   1    asynchronous active-low reset
//   req_rd   in   NCH  per-client read request (pulse or level)
//   req_wr   in   NCH  per-client write request
//   mounted  in   NCH  image (re)mounted; cancels that client's pending request
//   sd_rd    out  NCH  read strobe to hps_io
//   sd_wr    out  NCH  write strobe to hps_io
//   sd_ack   in   NCH  ack from hps_io
//   busy     out  NCH  client has a pending or active transfer (cpu_wait)
//   done     out  NCH  one-cycle pulse when the client's transfer finishes
//   grant    out  2    index of the active client, valid while active=1
//   active   out  1    a transfer is in progress
//   err      out  NCH  sticky timeout flag, cleared by the client's next request
// -----------------------------------------------------------------------------
module sd_req_sched #(
    parameter int NCH     = 3,
    parameter int TIMEOUT = 2**24
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    input  logic [NCH-1:0] req_rd,
    input  logic [NCH-1:0] req_wr,
    input  logic [NCH-1:0] mounted,
    output logic [NCH-1:0] sd_rd,
    output logic [NCH-1:0] sd_wr,
    input  logic [NCH-1:0] sd_ack,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done,
    output logic [1:0]     grant,
    output logic           active,
    output logic [NCH-1:0] err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One-hot vector with bit idx set.
    function automatic logic [NCH-1:0] onehot(input logic [1:0] idx);
        logic [NCH-1:0] vec_v;
        vec_v      = {NCH{1'b0}};
        vec_v[idx] = 1'b1;
        return vec_v;
    endfunction

    // Client index reached by stepping offset places from base, wrapping at NCH.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int offset);
        int sum_v;
        sum_v = int'(base) + offset;
        if (sum_v >= NCH) begin
            sum_v = sum_v - NCH;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[1:0];
    endfunction

    state_t         state_r,   state_nxt_s;
    logic [1:0]     grant_r,   grant_nxt_s;
    logic           active_r,  active_nxt_s;
    logic [1:0]     rr_ptr_r,  rr_nxt_s;
    logic           dir_wr_r,  dir_wr_nxt_s;
    logic [NCH-1:0] sd_rd_r,   sd_rd_nxt_s;
    logic [NCH-1:0] sd_wr_r,   sd_wr_nxt_s;
    logic [NCH-1:0] done_r,    done_nxt_s;
    logic [NCH-1:0] busy_r,    busy_nxt_s;
    logic [NCH-1:0] pend_rd_r, pend_rd_nxt_s;
    logic [NCH-1:0] pend_wr_r, pend_wr_nxt_s;
    logic [NCH-1:0] old_ack_r;
    logic [NCH-1:0] pend_any_s;
    logic [NCH-1:0] clr_rd_s;
    logic [NCH-1:0] clr_wr_s;
    logic           hit_s;
    logic [1:0]     hit_idx_s;
    logic           ack_rise_s;
    logic           ack_fall_s;

`ifdef SD_SCHED_TIMEOUT_EN
    logic [24:0]    tmo_cnt_r;
    logic           tmo_hit_s;
    logic [NCH-1:0] err_set_s;
    logic [NCH-1:0] err_r;
`endif

    // Keeps TIMEOUT referenced in every build; the block has no content.
    if (TIMEOUT < 1) begin : g_tmo_range
    end

    assign pend_any_s = pend_rd_r | pend_wr_r;

    // Only the granted client's ack is looked at; the others are ignored.
    assign ack_rise_s = sd_ack[grant_r] & ~old_ack_r[grant_r];
    assign ack_fall_s = ~sd_ack[grant_r] & old_ack_r[grant_r];

    // Round-robin search for the first pending client starting at rr_ptr.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 2'd0;
        for (int k = 0; k < NCH; k++) begin
            if (!hit_s && pend_any_s[rr_idx(rr_ptr_r, k)]) begin
                hit_s     = 1'b1;
                hit_idx_s = rr_idx(rr_ptr_r, k);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Transfer FSM: next state, strobes, done pulse and served-bit clears.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        active_nxt_s = active_r;
        rr_nxt_s     = rr_ptr_r;
        dir_wr_nxt_s = dir_wr_r;
        sd_rd_nxt_s  = sd_rd_r;
        sd_wr_nxt_s  = sd_wr_r;
        done_nxt_s   = {NCH{1'b0}};
        clr_rd_s     = {NCH{1'b0}};
        clr_wr_s     = {NCH{1'b0}};
`ifdef SD_SCHED_TIMEOUT_EN
        err_set_s    = {NCH{1'b0}};
`endif
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    grant_nxt_s  = hit_idx_s;
                    active_nxt_s = 1'b1;
                    state_nxt_s  = ST_REQ;
                    // Direction is frozen at grant time so a later request
                    // can never make both strobes high.
                    if (pend_wr_r[hit_idx_s]) begin
                        dir_wr_nxt_s = 1'b1;
                        sd_wr_nxt_s  = onehot(hit_idx_s);
                    end else begin
                        dir_wr_nxt_s = 1'b0;
                        sd_rd_nxt_s  = onehot(hit_idx_s);
                    end
                end else begin
                    active_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_rise_s) begin
                    sd_rd_nxt_s = {NCH{1'b0}};
                    sd_wr_nxt_s = {NCH{1'b0}};
                    state_nxt_s = ST_XFER;
                    if (dir_wr_r) begin
                        clr_wr_s = onehot(grant_r);
                    end else begin
                        clr_rd_s = onehot(grant_r);
                    end
                end
`ifdef SD_SCHED_TIMEOUT_EN
                else if (tmo_hit_s) begin
                    sd_rd_nxt_s = {NCH{1'b0}};
                    sd_wr_nxt_s = {NCH{1'b0}};
                    err_set_s   = onehot(grant_r);
                    done_nxt_s  = onehot(grant_r);
                    state_nxt_s = ST_DONE;
                    if (dir_wr_r) begin
                        clr_wr_s = onehot(grant_r);
                    end else begin
                        clr_rd_s = onehot(grant_r);
                    end
                end
`endif
                else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (ack_fall_s) begin
                    done_nxt_s  = onehot(grant_r);
                    state_nxt_s = ST_DONE;
                end
`ifdef SD_SCHED_TIMEOUT_EN
                else if (tmo_hit_s) begin
                    // The served bit was already cleared on ack rise.
                    err_set_s   = onehot(grant_r);
                    done_nxt_s  = onehot(grant_r);
                    state_nxt_s = ST_DONE;
                end
`endif
                else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: begin
                active_nxt_s = 1'b0;
                state_nxt_s  = ST_IDLE;
                if (grant_r == 2'(NCH - 1)) begin
                    rr_nxt_s = 2'd0;
                end else begin
                    rr_nxt_s = grant_r + 2'd1;
                end
            end
            default: begin
                active_nxt_s = 1'b0;
                sd_rd_nxt_s  = {NCH{1'b0}};
                sd_wr_nxt_s  = {NCH{1'b0}};
                state_nxt_s  = ST_IDLE;
            end
        endcase
    end

    // Pending latches and the busy image they produce one register later.
    // A new request beats the served-bit clear; mounted beats everything.
    always_comb begin
        pend_rd_nxt_s = ((pend_rd_r & ~clr_rd_s) | req_rd) & ~mounted;
        pend_wr_nxt_s = ((pend_wr_r & ~clr_wr_s) | req_wr) & ~mounted;
        if (active_nxt_s) begin
            busy_nxt_s = pend_rd_nxt_s | pend_wr_nxt_s | onehot(grant_nxt_s);
        end else begin
            busy_nxt_s = pend_rd_nxt_s | pend_wr_nxt_s;
        end
    end

    // State, pending and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= 2'd0;
            active_r  <= 1'b0;
            rr_ptr_r  <= 2'd0;
            dir_wr_r  <= 1'b0;
            sd_rd_r   <= {NCH{1'b0}};
            sd_wr_r   <= {NCH{1'b0}};
            done_r    <= {NCH{1'b0}};
            busy_r    <= {NCH{1'b0}};
            pend_rd_r <= {NCH{1'b0}};
            pend_wr_r <= {NCH{1'b0}};
            old_ack_r <= {NCH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            active_r  <= active_nxt_s;
            rr_ptr_r  <= rr_nxt_s;
            dir_wr_r  <= dir_wr_nxt_s;
            sd_rd_r   <= sd_rd_nxt_s;
            sd_wr_r   <= sd_wr_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= busy_nxt_s;
            pend_rd_r <= pend_rd_nxt_s;
            pend_wr_r <= pend_wr_nxt_s;
            old_ack_r <= sd_ack;
        end
    end

`ifdef SD_SCHED_TIMEOUT_EN
    // Watchdog fires on its last count, so strobes drop TIMEOUT cycles after grant.
    assign tmo_hit_s = (tmo_cnt_r == 25'(TIMEOUT - 1));

    // Watchdog counter, running only while a transfer is outstanding.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= 25'd0;
        end else if ((state_r == ST_REQ) || (state_r == ST_XFER)) begin
            tmo_cnt_r <= tmo_cnt_r + 25'd1;
        end else begin
            tmo_cnt_r <= 25'd0;
        end
    end

    // Sticky error flags: set by a timeout, cleared by the client's next request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= {NCH{1'b0}};
        end else begin
            err_r <= (err_r & ~(req_rd | req_wr)) | err_set_s;
        end
    end

    assign err = err_r;
`else
    assign err = {NCH{1'b0}};
`endif

    assign sd_rd  = sd_rd_r;
    assign sd_wr  = sd_wr_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign grant  = grant_r;
    assign active = active_r;

endmodule
